// File: rtl/keypad_time_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_time_entry_if
// Description : Keypad-side inputs and counter-load outputs of the time-entry
//               stage, bundled for connection between bench/top and block.
// Revision    : 1.0  initial release
// ============================================================================
interface keypad_time_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        timer_done;
    logic [15:0] digits;
    logic        loadn;
    logic        armed;
    logic        entry_active;
    logic        err;

    modport master (
        output key_valid, key_code, timer_done,
        input  digits, loadn, armed, entry_active, err
    );

    modport slave (
        input  key_valid, key_code, timer_done,
        output digits, loadn, armed, entry_active, err
    );
endinterface
`default_nettype wire

// File: rtl/keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_time_entry
// Description : Collects keypad digits into an MM:SS BCD cook time, validates
//               seconds-tens, strobes the digit counters and holds while armed.
// Revision    : 1.0  initial release
// ============================================================================
module keypad_time_entry #(
    parameter logic [3:0] QUICK_MIN_T = 4'd0,
    parameter logic [3:0] QUICK_MIN_U = 4'd0,
    parameter logic [3:0] QUICK_SEC_T = 4'd3,
    parameter logic [3:0] QUICK_SEC_U = 4'd0
) (
    input  wire logic             clk,
    input  wire logic             clrn,
    keypad_time_entry_if.slave    kif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_LOAD  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0]  c_KEY_START = 4'd10;
    localparam logic [3:0]  c_KEY_CLEAR = 4'd11;
    localparam logic [2:0]  c_MAX_DIGITS = 3'd4;
    localparam logic [15:0] c_QUICK_TIME = {QUICK_MIN_T, QUICK_MIN_U, QUICK_SEC_T, QUICK_SEC_U};

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_k_q;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [15:0] r_digits;
    logic [15:0] w_digits_nxt;
    logic        r_loadn;
    logic        r_armed;
    logic        r_entry_active;
    logic        r_err;
    logic        w_err_nxt;

    logic w_press;
    logic w_digit_press;
    logic w_start_press;
    logic w_clear_press;

    // A held key produces one event; codes 12-15 decode to nothing.
    assign w_press       = kif.key_valid & ~r_k_q;
    assign w_digit_press = w_press && (kif.key_code <= 4'd9);
    assign w_start_press = w_press && (kif.key_code == c_KEY_START);
    assign w_clear_press = w_press && (kif.key_code == c_KEY_CLEAR);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_digits_nxt = r_digits;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_digit_press) begin
                    w_digits_nxt = {r_digits[11:0], kif.key_code};
                    w_cnt_nxt    = 3'd1;
                    w_state_nxt  = S_ENTRY;
                end else if (w_start_press) begin
                    w_digits_nxt = c_QUICK_TIME;
                    w_state_nxt  = S_LOAD;
                end
            end
            S_ENTRY: begin
                if (w_digit_press) begin
                    if (r_cnt < c_MAX_DIGITS) begin
                        w_digits_nxt = {r_digits[11:0], kif.key_code};
                        w_cnt_nxt    = r_cnt + 3'd1;
                    end
                end else if (w_clear_press) begin
                    w_digits_nxt = 16'h0000;
                    w_cnt_nxt    = 3'd0;
                    w_state_nxt  = S_IDLE;
                end else if (w_start_press) begin
                    // Only seconds-tens can be illegal; minutes span 00-99.
                    if (r_digits[7:4] <= 4'd5) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_cnt_nxt   = 3'd0;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (kif.timer_done || w_clear_press) begin
                    w_digits_nxt = 16'h0000;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state        <= S_IDLE;
            r_k_q          <= 1'b0;
            r_cnt          <= 3'd0;
            r_digits       <= 16'h0000;
            r_loadn        <= 1'b1;
            r_armed        <= 1'b0;
            r_entry_active <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_k_q          <= kif.key_valid;
            r_cnt          <= w_cnt_nxt;
            r_digits       <= w_digits_nxt;
            // Status outputs are decoded from the next state so they line up
            // with r_state while coming straight from flops.
            r_loadn        <= (w_state_nxt != S_LOAD);
            r_armed        <= (w_state_nxt == S_HOLD);
            r_entry_active <= (w_state_nxt == S_ENTRY);
            r_err          <= w_err_nxt;
        end
    end

    assign kif.digits       = r_digits;
    assign kif.loadn        = r_loadn;
    assign kif.armed        = r_armed;
    assign kif.entry_active = r_entry_active;
    assign kif.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_time_entry
// Description : Directed per-cycle vector bench for keypad_time_entry.
// Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_time_entry;

    logic clk;
    logic clrn;
    int   checks;
    int   errors;

    keypad_time_entry_if kif ();

    keypad_time_entry dut (
        .clk  (clk),
        .clrn (clrn),
        .kif  (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        kv;
        logic [3:0]  code;
        logic        td;
        logic [15:0] d;
        logic        ln;
        logic        ar;
        logic        en;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic kv, input logic [3:0] code, input logic td,
                              input logic [15:0] d, input logic ln, input logic ar,
                              input logic en, input logic er);
        vec_t t;
        t.kv = kv; t.code = code; t.td = td;
        t.d = d; t.ln = ln; t.ar = ar; t.en = en; t.er = er;
        vecs.push_back(t);
    endfunction

    // Key held for 'hold' cycles then released for 'idle' cycles; outputs steady.
    function automatic void pr(input logic [3:0] c, input int hold, input int idle,
                               input logic [15:0] d, input logic ar, input logic en);
        for (int i = 0; i < hold; i++) v(1'b1, c, 1'b0, d, 1'b1, ar, en, 1'b0);
        for (int i = 0; i < idle; i++) v(1'b0, 4'd0, 1'b0, d, 1'b1, ar, en, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [15:0] d, input logic ln,
                       input logic ar, input logic en, input logic er);
        logic [19:0] act;
        logic [19:0] exp;
        act = {kif.digits, kif.loadn, kif.armed, kif.entry_active, kif.err};
        exp = {d, ln, ar, en, er};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got digits=%h loadn=%b armed=%b entry=%b err=%b, want digits=%h loadn=%b armed=%b entry=%b err=%b",
                     name, act[19:4], act[3], act[2], act[1], act[0],
                     exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            kif.key_valid  = vecs[i].kv;
            kif.key_code   = vecs[i].code;
            kif.timer_done = vecs[i].td;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", tag, i), vecs[i].d, vecs[i].ln, vecs[i].ar,
                vecs[i].en, vecs[i].er);
        end
        vecs.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clrn = 1'b0;
        kif.key_valid  = 1'b0;
        kif.key_code   = 4'd0;
        kif.timer_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // 1,2,3,0 then start: one loadn cycle, then armed
        pr(4'd1, 3, 2, 16'h0001, 1'b0, 1'b1);
        pr(4'd2, 3, 2, 16'h0012, 1'b0, 1'b1);
        pr(4'd3, 3, 2, 16'h0123, 1'b0, 1'b1);
        pr(4'd0, 3, 2, 16'h1230, 1'b0, 1'b1);
        v(1'b1, 4'd10, 1'b0, 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h1230, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h1230, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b1, 4'd11, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // held key counts once; fifth digit ignored
        pr(4'd4, 1, 1, 16'h0004, 1'b0, 1'b1);
        pr(4'd5, 10, 1, 16'h0045, 1'b0, 1'b1);
        v(1'b1, 4'd11, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        pr(4'd1, 1, 1, 16'h0001, 1'b0, 1'b1);
        pr(4'd2, 1, 1, 16'h0012, 1'b0, 1'b1);
        pr(4'd3, 1, 1, 16'h0123, 1'b0, 1'b1);
        pr(4'd4, 1, 1, 16'h1234, 1'b0, 1'b1);
        pr(4'd5, 1, 1, 16'h1234, 1'b0, 1'b1);
        // timer_done outside HOLD has no effect
        v(1'b0, 4'd0,  1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
        v(1'b1, 4'd11, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // illegal seconds-tens rejected
        pr(4'd9, 1, 1, 16'h0009, 1'b0, 1'b1);
        pr(4'd9, 1, 1, 16'h0099, 1'b0, 1'b1);
        v(1'b1, 4'd10, 1'b0, 16'h0099, 1'b1, 1'b0, 1'b1, 1'b1);
        v(1'b0, 4'd0,  1'b0, 16'h0099, 1'b1, 1'b0, 1'b1, 1'b0);
        v(1'b1, 4'd11, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // quick start, then timer_done
        v(1'b1, 4'd10, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0030, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // HOLD ignores digit/start; clear with timer_done together
        v(1'b1, 4'd10, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0030, 1'b1, 1'b1, 1'b0, 1'b0);
        pr(4'd7,  1, 1, 16'h0030, 1'b1, 1'b0);
        pr(4'd10, 1, 1, 16'h0030, 1'b1, 1'b0);
        v(1'b1, 4'd11, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // sec_t = 5 is the legal boundary
        pr(4'd5, 1, 1, 16'h0005, 1'b0, 1'b1);
        pr(4'd9, 1, 1, 16'h0059, 1'b0, 1'b1);
        v(1'b1, 4'd10, 1'b0, 16'h0059, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0059, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b1, 4'd11, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        // ignored codes, then "0" start with start held across LOAD->HOLD
        pr(4'd12, 1, 1, 16'h0000, 1'b0, 1'b0);
        pr(4'd15, 1, 1, 16'h0000, 1'b0, 1'b0);
        pr(4'd0,  1, 1, 16'h0000, 1'b0, 1'b1);
        v(1'b1, 4'd10, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b1, 4'd10, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b1, 4'd10, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vecs("main");

        // clrn asserted during the LOAD cycle
        kif.key_valid = 1'b1;
        kif.key_code  = 4'd10;
        @(posedge clk);
        #1;
        chk("midload_loadn_low", 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        clrn = 1'b0;
        #1;
        chk("midload_async_reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        kif.key_valid = 1'b0;
        kif.key_code  = 4'd0;
        @(posedge clk);
        #1;
        chk("midload_reset_hold", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        clrn = 1'b1;

        pr(4'd0, 1, 1, 16'h0000, 1'b0, 1'b1);
        pr(4'd5, 1, 1, 16'h0005, 1'b0, 1'b1);
        pr(4'd0, 1, 1, 16'h0050, 1'b0, 1'b1);
        pr(4'd0, 1, 1, 16'h0500, 1'b0, 1'b1);
        v(1'b1, 4'd10, 1'b0, 16'h0500, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b0, 16'h0500, 1'b1, 1'b1, 1'b0, 1'b0);
        v(1'b0, 4'd0,  1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vecs("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_time_entry.md
# keypad_time_entry

Upstream stage of the microwave timer. Converts decimal keypad presses into a 4-digit BCD cook time (MM:SS), checks that the seconds are legal, and drives the `data`/`loadn` load inputs of the four mod-10/mod-6 BCD down-counter digits. It then holds the armed state until the timer reports completion or the user clears.

## Interface
Parameters:
- `QUICK_MIN_T`, default 0: minutes-tens digit loaded by a start press with no digits entered.
- `QUICK_MIN_U`, default 0: minutes-units digit for quick start.
- `QUICK_SEC_T`, default 3: seconds-tens digit for quick start.
- `QUICK_SEC_U`, default 0: seconds-units digit for quick start.

Ports:
- `clk`  in  1  system clock.
- `clrn`  in  1  reset, asynchronous, active-low.
- `key_valid`  in  1  level, high while a key is held; already synchronous to `clk`.
- `key_code`  in  4  0–9 digit, 10 start, 11 clear, 12–15 ignored; valid while `key_valid` is high.
- `timer_done`  in  1  one-cycle pulse from timer control when the count reaches 00:00.
- `digits`  out  16  BCD {min_t, min_u, sec_t, sec_u}, bits 15:12 … 3:0; feeds the counter `data` inputs.
- `loadn`  out  1  active-low load strobe to all digit counters; exactly one cycle low.
- `armed`  out  1  high while a loaded time is owned by the timer.
- `entry_active`  out  1  high while at least one digit has been entered and not loaded.
- `err`  out  1  one-cycle pulse on a rejected start.

## Operation
- Press detect:
  - `k_q` registers `key_valid`.
  - press = `key_valid & ~k_q`. A held key yields exactly one press. A release followed by a new press is a new event.
- `cnt` (0–4) counts accepted digits.
- States: IDLE, ENTRY, LOAD, HOLD.
- IDLE (`cnt`=0):
  - digit press: `digits` <= {digits[11:0], code}, `cnt`=1, go to ENTRY.
  - start press: `digits` <= quick-start parameters, go to LOAD.
  - clear press: no effect.
- ENTRY:
  - digit press with `cnt`<4: shift left one nibble, insert at sec_u, `cnt`++.
  - digit press with `cnt`=4: ignored; `digits` and `cnt` unchanged.
  - clear press: `digits`=0, `cnt`=0, go to IDLE.
  - start press with `digits[7:4]` ≤ 5: go to LOAD.
  - start press with `digits[7:4]` > 5: `err` pulses for 1 cycle and the state stays ENTRY.
- Leading zeros are real digits. Pressing "0" increments `cnt`.
- LOAD: lasts 1 cycle and `loadn`=0. All key presses are ignored. Next state is HOLD with `cnt`=0.
- HOLD:
  - `armed`=1.
  - digit and start presses are ignored.
  - `timer_done` or clear press: `digits`=0, go to IDLE.
  - `timer_done` and clear press in the same cycle: same result.
- The start check applies only to seconds-tens. Minutes accept 00–99.
- An all-zero entry (e.g. "0", start) is legal and loads 0000.
- Key codes 12–15: ignored in every state; `k_q` still tracks them.
- `entry_active` = (state==ENTRY). `armed` = (state==HOLD). Both are registered state decodes.

## Timing
- Reset values: `digits`=0, `loadn`=1, `armed`=0, `entry_active`=0, `err`=0, `cnt`=0, `k_q`=0, state IDLE.
- `clrn` low forces all of the above immediately. This includes deasserting `loadn` mid-LOAD.
- Digit update: `digits` changes on the same edge that first samples `key_valid`=1 with `k_q`=0.
- Start to load:
  - edge N samples the start press and enters LOAD; `digits` are final at N.
  - `loadn` is low from after edge N until after edge N+1. It comes from a register, so it is glitch-free.
  - `armed` rises after N+1.
  - `digits` are stable for the whole cycle `loadn` is low.
- `err`: high for exactly the cycle after the edge that sampled the illegal start.
- `timer_done` in HOLD: IDLE and `digits`=0 after the next edge.
- A press coinciding with the LOAD cycle is consumed by the edge detector and lost; it is not replayed.
- `key_valid` held across the LOAD-to-HOLD transition produces no second event.

## Test plan
- Reset, then press 1,2,3,0 (each held 3 cycles, 2 idle), then start:
  - `digits`=16'h1230 and `cnt`=4 before start.
  - `loadn` low exactly 1 cycle; then `armed`=1 and `entry_active`=0.
- Press 4,5 and hold "5" for 10 cycles:
  - `digits`=16'h0045; only 2 digits accepted.
  - A fifth digit after 1,2,3,4 leaves 16'h1234.
- Press 9,9 then start:
  - sec_t=9, so `err` pulses 1 cycle, `loadn` stays 1, state ENTRY.
  - Then clear: `digits`=0, `entry_active`=0.
- Start from IDLE with default parameters:
  - `digits`=16'h0030, one `loadn` pulse.
  - Then `timer_done`: `armed`=0, `digits`=0.
- In HOLD, press digit 7 and start:
  - no change, no `loadn` pulse.
  - Clear and `timer_done` in the same cycle: IDLE, no error.
- Start accepted, then `clrn` low during the LOAD cycle:
  - `loadn` returns to 1 asynchronously; all outputs at reset values.
  - After release, entry of 0,5,0,0 then start loads 16'h0500.
